mem_req_ctrl: RTL and testbench

//  Initiator side of the single-port memory handshake (cs/mem_wr/mem_re/mem_done).

---
 rtl/mem_req_ctrl.sv | 171 +++++++++++++++++
 tb/tb_mem_req_ctrl.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_req_ctrl.sv
// Request queue and single-outstanding-op sequencer for the single-port memory
// handshake; returns one tagged response pulse per completed or timed-out op.
module mem_req_ctrl #(
  parameter int ADDR_WIDTH     = 20,
  parameter int TAG_WIDTH      = 4,
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [31:0]           req_wdata,
  input  logic [TAG_WIDTH-1:0]  req_tag,
  output logic                  resp_valid,
  output logic                  resp_we,
  output logic                  resp_err,
  output logic [TAG_WIDTH-1:0]  resp_tag,
  output logic [31:0]           resp_rdata,
  output logic                  mem_cs,
  output logic                  mem_wr,
  output logic                  mem_re,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  input  logic [31:0]           mem_rdata,
  input  logic                  mem_done,
  output logic                  busy
);

  localparam int PTR_W   = $clog2(FIFO_DEPTH);
  localparam int CNT_W   = $clog2(TIMEOUT_CYCLES) + 1;
  localparam int ENTRY_W = 1 + ADDR_WIDTH + 32 + TAG_WIDTH;

  localparam logic [PTR_W:0]   FULL_COUNT   = (PTR_W+1)'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;

  logic [ENTRY_W-1:0]    fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr_reg;
  logic [PTR_W-1:0]      rd_ptr_reg;
  logic [PTR_W:0]        count_reg;

  logic [1:0]            state_reg;
  logic [1:0]            state_next;
  logic [CNT_W-1:0]      cnt_reg;

  logic                  op_we_reg;
  logic [ADDR_WIDTH-1:0] op_addr_reg;
  logic [31:0]           op_wdata_reg;
  logic [TAG_WIDTH-1:0]  op_tag_reg;

  logic                  resp_valid_reg;
  logic                  resp_we_reg;
  logic                  resp_err_reg;
  logic [TAG_WIDTH-1:0]  resp_tag_reg;
  logic [31:0]           resp_rdata_reg;

  logic push;
  logic pop;
  logic fifo_empty;
  logic timeout_hit;
  logic op_finish;

  // req_ready comes only from the registered count, so a pop this cycle
  // cannot open a slot for a push in the same cycle.
  assign fifo_empty  = (count_reg == '0);
  assign req_ready   = (count_reg != FULL_COUNT);
  assign push        = req_valid & req_ready;
  assign pop         = (state_reg == IDLE) & ~fifo_empty;
  assign timeout_hit = (state_reg == WAIT) & (cnt_reg == TIMEOUT_LAST);
  assign op_finish   = (state_reg == WAIT) & (mem_done | timeout_hit);

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr_reg] <= {req_we, req_addr, req_wdata, req_tag};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count_reg <= count_reg + (PTR_W+1)'(1);
        2'b01:   count_reg <= count_reg - (PTR_W+1)'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (!fifo_empty) state_next = ISSUE;
      ISSUE:   state_next = WAIT;
      WAIT:    if (mem_done || timeout_hit) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= IDLE;
      cnt_reg        <= '0;
      op_we_reg      <= 1'b0;
      op_addr_reg    <= '0;
      op_wdata_reg   <= '0;
      op_tag_reg     <= '0;
      resp_valid_reg <= 1'b0;
      resp_we_reg    <= 1'b0;
      resp_err_reg   <= 1'b0;
      resp_tag_reg   <= '0;
      resp_rdata_reg <= '0;
    end else begin
      state_reg <= state_next;

      if (pop) begin
        {op_we_reg, op_addr_reg, op_wdata_reg, op_tag_reg} <= fifo_mem[rd_ptr_reg];
      end

      if (state_reg == ISSUE) begin
        cnt_reg <= '0;
      end else if (state_reg == WAIT) begin
        cnt_reg <= cnt_reg + CNT_W'(1);
      end

      // Response fields are zero outside the pulse; a done on the last
      // timeout cycle still counts as a normal completion.
      resp_valid_reg <= 1'b0;
      resp_we_reg    <= 1'b0;
      resp_err_reg   <= 1'b0;
      resp_tag_reg   <= '0;
      resp_rdata_reg <= '0;
      if (op_finish) begin
        resp_valid_reg <= 1'b1;
        resp_we_reg    <= op_we_reg;
        resp_err_reg   <= ~mem_done;
        resp_tag_reg   <= op_tag_reg;
        resp_rdata_reg <= (mem_done && !op_we_reg) ? mem_rdata : 32'd0;
      end
    end
  end

  assign mem_cs    = (state_reg == ISSUE) | (state_reg == WAIT);
  assign mem_wr    = (state_reg == ISSUE) & op_we_reg;
  assign mem_re    = (state_reg == ISSUE) & ~op_we_reg;
  assign mem_addr  = mem_cs ? op_addr_reg : '0;
  assign mem_wdata = mem_cs ? op_wdata_reg : 32'd0;

  assign resp_valid = resp_valid_reg;
  assign resp_we    = resp_we_reg;
  assign resp_err   = resp_err_reg;
  assign resp_tag   = resp_tag_reg;
  assign resp_rdata = resp_rdata_reg;

  assign busy = (state_reg != IDLE) | ~fifo_empty;

endmodule

// File: tb/tb_mem_req_ctrl.sv
// Bench for mem_req_ctrl: a memory model with per-request latency plus a
// scoreboard of expected responses, driven from a vector table and corner sequences.
module tb_mem_req_ctrl;

  localparam int AW    = 20;
  localparam int TW    = 4;
  localparam int DEPTH = 4;
  localparam int TMO   = 64;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid;
  logic          req_ready;
  logic          req_we;
  logic [AW-1:0] req_addr;
  logic [31:0]   req_wdata;
  logic [TW-1:0] req_tag;
  logic          resp_valid;
  logic          resp_we;
  logic          resp_err;
  logic [TW-1:0] resp_tag;
  logic [31:0]   resp_rdata;
  logic          mem_cs;
  logic          mem_wr;
  logic          mem_re;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic [31:0]   mem_rdata;
  logic          mem_done;
  logic          busy;

  always #5 clk = ~clk;

  mem_req_ctrl #(
    .ADDR_WIDTH(AW), .TAG_WIDTH(TW), .FIFO_DEPTH(DEPTH), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_tag(req_tag),
    .resp_valid(resp_valid), .resp_we(resp_we), .resp_err(resp_err),
    .resp_tag(resp_tag), .resp_rdata(resp_rdata),
    .mem_cs(mem_cs), .mem_wr(mem_wr), .mem_re(mem_re),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_done(mem_done), .busy(busy)
  );

  typedef struct {
    logic          we;
    logic [AW-1:0] addr;
    logic [31:0]   wdata;
    logic [TW-1:0] tag;
    int            lat;
  } vec_t;

  typedef struct {
    logic          we;
    logic          err;
    logic [TW-1:0] tag;
    logic [AW-1:0] addr;
    logic [31:0]   wdata;
    logic [31:0]   rdata;
    int            lat;
    int            acc_cyc;
    bit            chk_acc;
  } exp_t;

  exp_t          sb[$];
  logic [31:0]   ref_mem [int];
  logic [31:0]   mod_mem [int];
  int            errors = 0;
  int            checks = 0;
  int            cyc = 0;
  int            cd = -1;
  int            issue_cyc = 0;
  bit            in_flight = 1'b0;
  bit            prev_strobe = 1'b0;
  logic [AW-1:0] held_addr;
  logic [31:0]   held_wdata;
  logic [31:0]   rd_val;

  function automatic logic [31:0] fill(input logic [AW-1:0] a);
    return {12'hC3C, a};
  endfunction

  task automatic chk(input string name, input bit ok, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s actual=%08h required=%08h cyc=%0d", name, act, req, cyc);
    end
  endtask

  // Advance to the next falling edge, run the memory model, then check outputs.
  task automatic tick();
    bit   strobe;
    exp_t e;
    int   lat;
    int   exp_lat;
    @(negedge clk);
    cyc++;
    strobe    = mem_wr | mem_re;
    mem_done  = 1'b0;
    mem_rdata = $urandom;
    if (rst) begin
      cd          = -1;
      in_flight   = 1'b0;
      prev_strobe = 1'b0;
    end else begin
      if (in_flight && !strobe && !resp_valid)
        chk("wait_hold", mem_cs && !mem_wr && !mem_re && mem_addr == held_addr && mem_wdata == held_wdata,
            32'(mem_addr), 32'(held_addr));
      if (!in_flight && !strobe)
        chk("idle_mem_off", !mem_cs && mem_addr == '0 && mem_wdata == '0, {31'd0, mem_cs}, 32'd0);
      if (strobe) begin
        chk("strobe_width", !prev_strobe, 32'(prev_strobe), 32'd0);
        if (sb.size() == 0) begin
          chk("issue_unexpected", 1'b0, 32'(mem_addr), 32'd0);
          lat = 2;
        end else begin
          e = sb[0];
          lat = e.lat;
          chk("issue_kind", mem_cs && mem_wr == e.we && mem_re == !e.we, {29'd0, mem_cs, mem_wr, mem_re},
              {29'd0, 1'b1, e.we, !e.we});
          chk("issue_addr", mem_addr == e.addr, 32'(mem_addr), 32'(e.addr));
          if (e.we) chk("issue_wdata", mem_wdata == e.wdata, mem_wdata, e.wdata);
        end
        held_addr  = mem_addr;
        held_wdata = mem_wdata;
        in_flight  = 1'b1;
        issue_cyc  = cyc;
        if (mem_wr) mod_mem[int'(mem_addr)] = mem_wdata;
        else rd_val = mod_mem.exists(int'(mem_addr)) ? mod_mem[int'(mem_addr)] : fill(mem_addr);
        cd = (lat == 0) ? -1 : lat;
      end else if (cd > 0) begin
        cd--;
        if (cd == 0) begin
          mem_done  = 1'b1;
          mem_rdata = rd_val;
          cd        = -1;
        end
      end
      if (resp_valid) begin
        if (sb.size() == 0) begin
          chk("resp_unexpected", 1'b0, 32'(resp_tag), 32'd0);
        end else begin
          e = sb.pop_front();
          $display("resp tag=%0h we=%0b err=%0b rdata=%08h cyc=%0d", resp_tag, resp_we, resp_err, resp_rdata, cyc);
          chk("resp_tag", resp_tag == e.tag, 32'(resp_tag), 32'(e.tag));
          chk("resp_we", resp_we == e.we, 32'(resp_we), 32'(e.we));
          chk("resp_err", resp_err == e.err, 32'(resp_err), 32'(e.err));
          chk("resp_rdata", resp_rdata == e.rdata, resp_rdata, e.rdata);
          exp_lat = e.err ? TMO + 1 : e.lat + 1;
          chk("resp_lat_issue", cyc - issue_cyc == exp_lat, 32'(cyc - issue_cyc), 32'(exp_lat));
          if (e.chk_acc)
            chk("resp_lat_accept", cyc - e.acc_cyc == exp_lat + 1, 32'(cyc - e.acc_cyc), 32'(exp_lat + 1));
        end
        in_flight = 1'b0;
      end
    end
    prev_strobe = strobe;
  endtask

  task automatic send(input logic we, input logic [AW-1:0] a, input logic [31:0] d, input logic [TW-1:0] t,
                      input int lat, input bit chk_acc, output bit acc);
    exp_t e;
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = a;
    req_wdata = d;
    req_tag   = t;
    acc       = req_ready;
    if (acc) begin
      e.err     = (lat == 0) || (lat > TMO);
      e.we      = we;
      e.tag     = t;
      e.addr    = a;
      e.wdata   = d;
      e.lat     = lat;
      e.acc_cyc = cyc + 1;
      e.chk_acc = chk_acc;
      e.rdata   = (we || e.err) ? 32'd0 : (ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : fill(a));
      if (we) ref_mem[int'(a)] = d;
      sb.push_back(e);
    end
    tick();
    req_valid = 1'b0;
  endtask

  task automatic drain(input int budget);
    for (int i = 0; i < budget && sb.size() > 0; i++) tick();
    chk("drain_done", sb.size() == 0, 32'(sb.size()), 32'd0);
    tick();
    chk("idle_not_busy", !busy, 32'(busy), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[8];
    bit   acc;

    vecs[0] = '{1'b1, 20'h00001, 32'h0000_0005, 4'h2, 10};
    vecs[1] = '{1'b0, 20'h00001, 32'h0000_0000, 4'h3, 10};
    vecs[2] = '{1'b1, 20'hFFFFF, 32'hFFFF_FFFF, 4'hF, 1};
    vecs[3] = '{1'b0, 20'hFFFFF, 32'h0000_0000, 4'h1, 1};
    vecs[4] = '{1'b0, 20'h00ABC, 32'h0000_0000, 4'h7, 5};
    vecs[5] = '{1'b1, 20'h00ABC, 32'h1234_ABCD, 4'h8, TMO};
    vecs[6] = '{1'b0, 20'h00ABC, 32'h0000_0000, 4'h9, 0};
    vecs[7] = '{1'b0, 20'h00ABC, 32'h0000_0000, 4'hA, TMO + 1};

    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0; req_tag = '0;
    mem_done = 1'b0; mem_rdata = '0;
    tick();
    tick();
    chk("rst_ready", req_ready, 32'(req_ready), 32'd1);
    chk("rst_resp", {resp_valid, resp_we, resp_err} == 3'b000 && resp_tag == '0 && resp_rdata == '0,
        {29'd0, resp_valid, resp_we, resp_err}, 32'd0);
    chk("rst_mem", {mem_cs, mem_wr, mem_re} == 3'b000 && mem_addr == '0 && mem_wdata == '0,
        {29'd0, mem_cs, mem_wr, mem_re}, 32'd0);
    chk("rst_busy", !busy, 32'(busy), 32'd0);
    rst = 1'b0;
    tick();

    for (int i = 0; i < 8; i++) begin
      send(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].tag, vecs[i].lat, 1'b1, acc);
      chk("vec_accept", acc, 32'(acc), 32'd1);
      drain(200);
    end

    // Burst of loads behind a slow op: four queue, the fifth must be refused.
    send(1'b0, 20'h00001, 32'd0, 4'hB, 40, 1'b1, acc);
    for (int t = 0; t < 5; t++) begin
      send(1'b0, AW'(20'h00100 + t), 32'd0, TW'(t), 3, 1'b0, acc);
      chk($sformatf("burst_accept_t%0d", t), acc == (t < DEPTH), 32'(acc), 32'(t < DEPTH));
    end
    drain(400);

    // Stray mem_done while idle must not create a response or busy.
    mem_done = 1'b1;
    tick();
    for (int i = 0; i < 3; i++) begin
      chk("stray_done_no_resp", !resp_valid, 32'(resp_valid), 32'd0);
      chk("stray_done_not_busy", !busy, 32'(busy), 32'd0);
      tick();
    end

    // Reset three cycles into WAIT with two requests queued.
    send(1'b1, 20'h00777, 32'hCAFE_0001, 4'h4, 30, 1'b1, acc);
    send(1'b0, 20'h00001, 32'd0, 4'h5, 3, 1'b0, acc);
    send(1'b0, 20'h00002, 32'd0, 4'h6, 3, 1'b0, acc);
    tick();
    tick();
    chk("pre_rst_cs", mem_cs, 32'(mem_cs), 32'd1);
    rst = 1'b1;
    sb.delete();
    tick();
    chk("post_rst_cs", !mem_cs, 32'(mem_cs), 32'd0);
    chk("post_rst_ready", req_ready, 32'(req_ready), 32'd1);
    chk("post_rst_busy", !busy, 32'(busy), 32'd0);
    chk("post_rst_resp", !resp_valid, 32'(resp_valid), 32'd0);
    rst = 1'b0;
    ref_mem = mod_mem;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("post_rst_quiet", !resp_valid && !busy, {30'd0, resp_valid, busy}, 32'd0);
    end
    send(1'b1, 20'h00042, 32'h0000_BEEF, 4'hC, 4, 1'b1, acc);
    drain(100);
    send(1'b0, 20'h00042, 32'd0, 4'hD, 2, 1'b1, acc);
    drain(100);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
